// File: rtl/lc4_branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters for LC4 fetch.
// F-stage lookup is combinational; X-stage resolution updates the table and the performance counters.
module lc4_branch_predictor #(
    parameter int ENTRIES  = 16,
    parameter int PC_W     = 16,
    parameter int CTR_BITS = 2,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gwe,
    input  logic [PC_W-1:0]   i_f_pc,
    output logic              o_f_pred_taken,
    output logic [PC_W-1:0]   o_f_pred_target,
    input  logic              i_x_valid,
    input  logic [PC_W-1:0]   i_x_pc,
    input  logic              i_x_uncond,
    input  logic              i_x_taken,
    input  logic [PC_W-1:0]   i_x_target,
    input  logic              i_x_pred_taken,
    input  logic [PC_W-1:0]   i_x_pred_target,
    output logic              o_x_mispredict,
    output logic [PC_W-1:0]   o_x_redirect_pc,
    output logic [STAT_W-1:0] o_stat_lookups,
    output logic [STAT_W-1:0] o_stat_mispredicts
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX;

    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(2 ** (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(2 ** (CTR_BITS - 1) - 1);
    localparam logic [STAT_W-1:0]   STAT_MAX = '1;

    logic                r_valid  [ENTRIES];
    logic [TAG_W-1:0]    r_tag    [ENTRIES];
    logic [PC_W-1:0]     r_target [ENTRIES];
    logic [CTR_BITS-1:0] r_ctr    [ENTRIES];

    logic [STAT_W-1:0]   r_stat_lookups;
    logic [STAT_W-1:0]   r_stat_mispredicts;

    logic [IDX-1:0]      w_f_idx;
    logic [TAG_W-1:0]    w_f_tag;
    logic                w_f_hit;
    logic [IDX-1:0]      w_x_idx;
    logic [TAG_W-1:0]    w_x_tag;
    logic                w_x_hit;
    logic                w_x_eff_taken;
    logic                w_x_update;
    logic                w_x_mispredict;

    // Fetch-side lookup
    assign w_f_idx = i_f_pc[IDX-1:0];
    assign w_f_tag = i_f_pc[PC_W-1:IDX];
    assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);

    assign o_f_pred_taken  = w_f_hit && r_ctr[w_f_idx][CTR_BITS-1];
    assign o_f_pred_target = o_f_pred_taken ? r_target[w_f_idx] : i_f_pc + PC_W'(1);

    // Resolution-side check
    assign w_x_idx       = i_x_pc[IDX-1:0];
    assign w_x_tag       = i_x_pc[PC_W-1:IDX];
    assign w_x_hit       = r_valid[w_x_idx] && (r_tag[w_x_idx] == w_x_tag);
    assign w_x_eff_taken = i_x_taken || i_x_uncond;
    assign w_x_update    = gwe && i_x_valid;

    assign w_x_mispredict = i_x_valid &&
                            ((i_x_pred_taken != i_x_taken) ||
                             (i_x_taken && (i_x_pred_target != i_x_target)));

    assign o_x_mispredict  = w_x_mispredict;
    assign o_x_redirect_pc = !i_x_valid ? '0 :
                             i_x_taken  ? i_x_target : i_x_pc + PC_W'(1);

    assign o_stat_lookups     = r_stat_lookups;
    assign o_stat_mispredicts = r_stat_mispredicts;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CTR_WNT;
            end
        end else if (w_x_update) begin
            if (w_x_hit) begin
                if (w_x_eff_taken) begin
                    r_target[w_x_idx] <= i_x_target;
                    if (i_x_uncond || r_ctr[w_x_idx] == CTR_MAX)
                        r_ctr[w_x_idx] <= CTR_MAX;
                    else
                        r_ctr[w_x_idx] <= r_ctr[w_x_idx] + CTR_BITS'(1);
                end else if (r_ctr[w_x_idx] != '0) begin
                    r_ctr[w_x_idx] <= r_ctr[w_x_idx] - CTR_BITS'(1);
                end
            end else if (w_x_eff_taken) begin
                // Miss and taken: claim the slot, evicting whatever aliased there
                r_valid[w_x_idx]  <= 1'b1;
                r_tag[w_x_idx]    <= w_x_tag;
                r_target[w_x_idx] <= i_x_target;
                r_ctr[w_x_idx]    <= i_x_uncond ? CTR_MAX : CTR_WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_lookups     <= '0;
            r_stat_mispredicts <= '0;
        end else if (gwe) begin
            if (i_x_valid && r_stat_lookups != STAT_MAX)
                r_stat_lookups <= r_stat_lookups + STAT_W'(1);
            if (w_x_mispredict && r_stat_mispredicts != STAT_MAX)
                r_stat_mispredicts <= r_stat_mispredicts + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_lc4_branch_predictor.sv
// Scoreboarded bench for lc4_branch_predictor: directed scenarios followed by random traffic,
// with expectations produced by a table-of-last-branch reference model.
module tb_lc4_branch_predictor;

    localparam int ENTRIES  = 16;
    localparam int PC_W     = 16;
    localparam int CTR_BITS = 2;
    localparam int STAT_W   = 6;
    localparam int CTR_MAXV = (1 << CTR_BITS) - 1;
    localparam int CTR_HALF = 1 << (CTR_BITS - 1);
    localparam int STAT_MAXV = (1 << STAT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              gwe = 1'b1;
    logic [PC_W-1:0]   i_f_pc = '0;
    logic              o_f_pred_taken;
    logic [PC_W-1:0]   o_f_pred_target;
    logic              i_x_valid = 1'b0;
    logic [PC_W-1:0]   i_x_pc = '0;
    logic              i_x_uncond = 1'b0;
    logic              i_x_taken = 1'b0;
    logic [PC_W-1:0]   i_x_target = '0;
    logic              i_x_pred_taken = 1'b0;
    logic [PC_W-1:0]   i_x_pred_target = '0;
    logic              o_x_mispredict;
    logic [PC_W-1:0]   o_x_redirect_pc;
    logic [STAT_W-1:0] o_stat_lookups;
    logic [STAT_W-1:0] o_stat_mispredicts;

    lc4_branch_predictor #(
        .ENTRIES(ENTRIES), .PC_W(PC_W), .CTR_BITS(CTR_BITS), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .rst(rst), .gwe(gwe),
        .i_f_pc(i_f_pc), .o_f_pred_taken(o_f_pred_taken), .o_f_pred_target(o_f_pred_target),
        .i_x_valid(i_x_valid), .i_x_pc(i_x_pc), .i_x_uncond(i_x_uncond),
        .i_x_taken(i_x_taken), .i_x_target(i_x_target),
        .i_x_pred_taken(i_x_pred_taken), .i_x_pred_target(i_x_pred_target),
        .o_x_mispredict(o_x_mispredict), .o_x_redirect_pc(o_x_redirect_pc),
        .o_stat_lookups(o_stat_lookups), .o_stat_mispredicts(o_stat_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ft;
        logic [15:0] ftgt;
        bit          mis;
        logic [15:0] red;
        int          lk;
        int          mp;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: each slot remembers the full PC of the branch that owns it.
    bit          m_valid [ENTRIES];
    logic [15:0] m_pc    [ENTRIES];
    logic [15:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int          m_lk;
    int          m_mp;

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0;
            m_pc[i]    = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = CTR_HALF - 1;
        end
        m_lk = 0;
        m_mp = 0;
    endfunction

    function automatic void m_lookup(input logic [15:0] pc, output bit t, output logic [15:0] tgt);
        int s;
        s = int'(pc) % ENTRIES;
        t = m_valid[s] && (m_pc[s] == pc) && (m_ctr[s] >= CTR_HALF);
        tgt = t ? m_tgt[s] : 16'((int'(pc) + 1) % 65536);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pred_taken",  32'(o_f_pred_taken),     32'(e.ft));
            chk("pred_target", 32'(o_f_pred_target),    32'(e.ftgt));
            chk("mispredict",  32'(o_x_mispredict),     32'(e.mis));
            chk("redirect_pc", 32'(o_x_redirect_pc),    32'(e.red));
            chk("stat_lookups",     32'(o_stat_lookups),     32'(e.lk));
            chk("stat_mispredicts", 32'(o_stat_mispredicts), 32'(e.mp));
        end
    end

    // Drive one cycle of inputs, record the expected outputs, then advance the model past the next edge.
    task automatic step(input bit r, input bit g, input logic [15:0] fpc,
                        input bit xv, input logic [15:0] xpc, input bit xu, input bit xt,
                        input logic [15:0] xtgt, input bit xpt, input logic [15:0] xptgt);
        exp_t e;
        bit   mis;
        bit   hit;
        bit   tk;
        int   s;
        @(posedge clk);
        #1;
        rst = r; gwe = g; i_f_pc = fpc;
        i_x_valid = xv; i_x_pc = xpc; i_x_uncond = xu; i_x_taken = xt;
        i_x_target = xtgt; i_x_pred_taken = xpt; i_x_pred_target = xptgt;

        m_lookup(fpc, e.ft, e.ftgt);
        mis   = xv && ((xpt != xt) || (xt && xptgt != xtgt));
        e.mis = mis;
        e.red = !xv ? 16'h0 : (xt ? xtgt : 16'((int'(xpc) + 1) % 65536));
        e.lk  = m_lk;
        e.mp  = m_mp;
        q.push_back(e);

        if (r) begin
            m_reset();
        end else if (g) begin
            if (xv) begin
                s   = int'(xpc) % ENTRIES;
                hit = m_valid[s] && (m_pc[s] == xpc);
                tk  = xt || xu;
                if (hit && tk) begin
                    m_tgt[s] = xtgt;
                    m_ctr[s] = xu ? CTR_MAXV : ((m_ctr[s] + 1 > CTR_MAXV) ? CTR_MAXV : m_ctr[s] + 1);
                end else if (hit) begin
                    m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
                end else if (tk) begin
                    m_valid[s] = 1;
                    m_pc[s]    = xpc;
                    m_tgt[s]   = xtgt;
                    m_ctr[s]   = xu ? CTR_MAXV : CTR_HALF;
                end
                if (m_lk < STAT_MAXV) m_lk++;
            end
            if (mis && m_mp < STAT_MAXV) m_mp++;
        end
    endtask

    task automatic idle(input logic [15:0] fpc);
        step(0, 1, fpc, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
    endtask

    task automatic br(input logic [15:0] fpc, input logic [15:0] xpc, input bit xt,
                      input logic [15:0] xtgt, input bit xpt, input logic [15:0] xptgt);
        step(0, 1, fpc, 1, xpc, 0, xt, xtgt, xpt, xptgt);
    endtask

    initial begin
        logic [15:0] pc;
        logic [15:0] tgt;
        logic [15:0] ptgt;
        bit          pt;
        bit          mt;
        logic [15:0] mtgt;
        int          wait_cyc;

        m_reset();
        repeat (2) @(posedge clk);

        idle(16'h8200);
        br(16'h8203, 16'h8203, 1, 16'h8210, 0, 16'h8204);
        idle(16'h8203);
        repeat (3) br(16'h8203, 16'h8203, 1, 16'h8210, 1, 16'h8210);
        br(16'h8203, 16'h8203, 0, 16'h8210, 1, 16'h8210);
        idle(16'h8203);
        br(16'h8203, 16'h8203, 0, 16'h8210, 1, 16'h8210);
        idle(16'h8203);

        br(16'h8203, 16'h8203, 1, 16'h8210, 0, 16'h8204);
        br(16'h8213, 16'h8213, 1, 16'h8300, 0, 16'h8214);
        idle(16'h8203);
        idle(16'h8213);

        br(16'h8205, 16'h8205, 1, 16'h9000, 0, 16'h8206);
        idle(16'h8205);
        step(0, 0, 16'h8206, 1, 16'h8206, 0, 1, 16'h9100, 0, 16'h8207);
        idle(16'h8206);

        step(0, 1, 16'hFFFF, 1, 16'hFFFF, 0, 0, 16'h1234, 1, 16'h1234);
        step(0, 1, 16'h8207, 1, 16'h8207, 1, 1, 16'h7000, 0, 16'h8208);
        idle(16'h8207);
        step(0, 1, 16'h8207, 1, 16'h8207, 0, 0, 16'h7000, 1, 16'h7000);
        idle(16'h8207);
        step(0, 1, 16'h8207, 0, 16'h8207, 0, 1, 16'h7000, 0, 16'h0);

        repeat (5) br(16'h8213, 16'h8213, 1, 16'h8300, 0, 16'h8214);
        step(1, 1, 16'h8213, 1, 16'h8213, 0, 1, 16'h8300, 0, 16'h8214);
        idle(16'h8213);
        idle(16'h8205);

        for (int n = 0; n < 600; n++) begin
            pc  = 16'h8000 | 16'($urandom_range(0, 3) << 4) | 16'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) pc = 16'hFFFF;
            tgt = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 7) + 16'h9000) : 16'($urandom);
            m_lookup(pc, mt, mtgt);
            if ($urandom_range(0, 1) == 0) begin
                pt = mt; ptgt = mtgt;
            end else begin
                pt = 1'($urandom); ptgt = ($urandom_range(0, 1) == 0) ? tgt : 16'($urandom);
            end
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 1) == 0) ? pc : (16'h8000 | 16'($urandom_range(0, 63))),
                 ($urandom_range(0, 9) < 7), pc, ($urandom_range(0, 7) == 0),
                 1'($urandom), tgt, pt, ptgt);
        end

        idle(16'h0000);
        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
